// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Define ALU_ARB_FIXED_PRIO_EN to make port 0 always win under contention.
module alu_arbiter #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic [1:0]               req_valid,
  output logic [1:0]               req_ready,
  input  logic [DATA_WIDTH-1:0]    req0_SrcA,
  input  logic [DATA_WIDTH-1:0]    req0_SrcB,
  input  logic [OPCODE_LENGTH-1:0] req0_Operation,
  input  logic [DATA_WIDTH-1:0]    req1_SrcA,
  input  logic [DATA_WIDTH-1:0]    req1_SrcB,
  input  logic [OPCODE_LENGTH-1:0] req1_Operation,

  output logic [DATA_WIDTH-1:0]    alu_SrcA,
  output logic [DATA_WIDTH-1:0]    alu_SrcB,
  output logic [OPCODE_LENGTH-1:0] alu_Operation,
  input  logic [DATA_WIDTH-1:0]    alu_ALUResult,

  output logic [1:0]               rsp_valid,
  input  logic [1:0]               rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     rsp_err
);

  localparam logic [OPCODE_LENGTH-1:0] OpIllegalA = OPCODE_LENGTH'(4'b1101);
  localparam logic [OPCODE_LENGTH-1:0] OpIllegalB = OPCODE_LENGTH'(4'b1110);

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  state_e                   state_q;
  logic                     owner_q;
  logic                     last_grant_q;
  logic [DATA_WIDTH-1:0]    src_a_q;
  logic [DATA_WIDTH-1:0]    src_b_q;
  logic [OPCODE_LENGTH-1:0] op_q;
  logic [1:0]               rsp_valid_q;
  logic [DATA_WIDTH-1:0]    rsp_data_q;
  logic                     rsp_err_q;

  logic                     grant_valid;
  logic                     grant_idx;
  logic [DATA_WIDTH-1:0]    sel_src_a;
  logic [DATA_WIDTH-1:0]    sel_src_b;
  logic [OPCODE_LENGTH-1:0] sel_op;
  logic                     op_illegal;

  // Grant is only offered in IDLE; reset suppresses it so nothing is accepted.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 1'b0;
    if (state_q == StIdle && !reset) begin
      case (req_valid)
        2'b01: begin
          grant_valid = 1'b1;
          grant_idx   = 1'b0;
        end
        2'b10: begin
          grant_valid = 1'b1;
          grant_idx   = 1'b1;
        end
        2'b11: begin
          grant_valid = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
          grant_idx   = 1'b0;
`else
          grant_idx   = ~last_grant_q;
`endif
        end
        default: begin
          grant_valid = 1'b0;
          grant_idx   = 1'b0;
        end
      endcase
    end
  end

  assign req_ready = grant_valid ? (2'b01 << grant_idx) : 2'b00;

  always_comb begin
    sel_src_a = req0_SrcA;
    sel_src_b = req0_SrcB;
    sel_op    = req0_Operation;
    if (grant_idx) begin
      sel_src_a = req1_SrcA;
      sel_src_b = req1_SrcB;
      sel_op    = req1_Operation;
    end
  end

  assign op_illegal = (op_q == OpIllegalA) || (op_q == OpIllegalB);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      src_a_q      <= '0;
      src_b_q      <= '0;
      op_q         <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant_valid) begin
            src_a_q      <= sel_src_a;
            src_b_q      <= sel_src_b;
            op_q         <= sel_op;
            owner_q      <= grant_idx;
            last_grant_q <= grant_idx;
            state_q      <= StExec;
          end
        end
        StExec: begin
          rsp_data_q  <= alu_ALUResult;
          rsp_err_q   <= op_illegal;
          rsp_valid_q <= 2'b01 << owner_q;
          state_q     <= StResp;
        end
        StResp: begin
          // Only the owner's ready retires the response; data/err stay visible.
          if (rsp_ready[owner_q]) begin
            rsp_valid_q <= 2'b00;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign alu_SrcA      = (state_q == StExec) ? src_a_q : '0;
  assign alu_SrcB      = (state_q == StExec) ? src_b_q : '0;
  assign alu_Operation = (state_q == StExec) ? op_q : '0;

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU and a response scoreboard.
module tb_alu_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req0_SrcA, req0_SrcB, req1_SrcA, req1_SrcB;
  logic [3:0]  req0_Operation, req1_Operation;
  logic [31:0] alu_SrcA, alu_SrcB, alu_ALUResult;
  logic [3:0]  alu_Operation;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  typedef struct packed {
    logic        port;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  alu_arbiter #(
    .DATA_WIDTH   (32),
    .OPCODE_LENGTH(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req0_SrcA     (req0_SrcA),
    .req0_SrcB     (req0_SrcB),
    .req0_Operation(req0_Operation),
    .req1_SrcA     (req1_SrcA),
    .req1_SrcB     (req1_SrcB),
    .req1_Operation(req1_Operation),
    .alu_SrcA      (alu_SrcA),
    .alu_SrcB      (alu_SrcB),
    .alu_Operation (alu_Operation),
    .alu_ALUResult (alu_ALUResult),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural ALU: only the ops exercised here; illegal/unknown ops give 0.
  always_comb begin
    alu_ALUResult = '0;
    case (alu_Operation)
      4'b0010: alu_ALUResult = alu_SrcA + alu_SrcB;
      4'b0011: alu_ALUResult = alu_SrcA - alu_SrcB;
      4'b0110: alu_ALUResult = alu_SrcA | alu_SrcB;
      4'b0111: alu_ALUResult = $signed(alu_SrcA) >>> alu_SrcB[4:0];
      4'b1000: alu_ALUResult = {31'b0, alu_SrcA == alu_SrcB};
      default: alu_ALUResult = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every completed response handshake pops one expectation.
  always @(negedge clk) begin
    if (!reset && (rsp_valid & rsp_ready) != 2'b00) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", {30'b0, rsp_valid}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_port", {30'b0, rsp_valid}, {30'b0, 2'b01 << e.port});
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
      end
    end
  end

  task automatic do_op(input logic p, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic [31:0] exp_d, input logic exp_e);
    bit done;
    if (p) begin
      req1_SrcA = a; req1_SrcB = b; req1_Operation = op;
    end else begin
      req0_SrcA = a; req0_SrcB = b; req0_Operation = op;
    end
    req_valid[p] = 1'b1;
    rsp_ready    = 2'b11;
    sb.push_back('{port: p, data: exp_d, err: exp_e});
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (req_ready[p]) done = 1'b1;
      tick();
    end
    if (!done) chk("accept_timeout", 32'h0, 32'h1);
    req_valid[p] = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if ((rsp_valid & rsp_ready) != 2'b00) done = 1'b1;
      tick();
    end
    if (!done) chk("rsp_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] exp_g1;
    reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    req0_SrcA = '0; req0_SrcB = '0; req0_Operation = '0;
    req1_SrcA = '0; req1_SrcB = '0; req1_Operation = '0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_rsp_valid", {30'b0, rsp_valid}, 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
    chk("rst_alu_a", alu_SrcA, 32'h0);
    chk("rst_alu_op", {28'b0, alu_Operation}, 32'h0);
    chk("rst_req_ready", {30'b0, req_ready}, 32'h0);
    tick();
    reset = 1'b0;
    tick();

    // Single request with explicit latency checks.
    req0_SrcA = 32'd5; req0_SrcB = 32'd7; req0_Operation = 4'b0010;
    req_valid = 2'b01;
    sb.push_back('{port: 1'b0, data: 32'd12, err: 1'b0});
    @(negedge clk);
    chk("t1_ready_c0", {30'b0, req_ready}, 32'h1);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    chk("t1_ready_c1", {30'b0, req_ready}, 32'h0);
    chk("t1_valid_c1", {30'b0, rsp_valid}, 32'h0);
    chk("t1_alu_a_c1", alu_SrcA, 32'd5);
    chk("t1_alu_op_c1", {28'b0, alu_Operation}, 32'h2);
    tick();
    rsp_ready = 2'b01;
    @(negedge clk);
    chk("t1_ready_c2", {30'b0, req_ready}, 32'h0);
    chk("t1_valid_c2", {30'b0, rsp_valid}, 32'h1);
    chk("t1_alu_a_c2", alu_SrcA, 32'h0);
    tick();
    @(negedge clk);
    chk("t1_valid_c3", {30'b0, rsp_valid}, 32'h0);
    chk("t1_data_hold", rsp_data, 32'd12);
    tick();

    // Contention from a fresh reset so port 0 has first priority.
    reset = 1'b1; tick(); reset = 1'b0;
    req0_SrcA = 32'd10;   req0_SrcB = 32'd3;    req0_Operation = 4'b0011;
    req1_SrcA = 32'hF0;   req1_SrcB = 32'h0F;   req1_Operation = 4'b0110;
    req_valid = 2'b11; rsp_ready = 2'b11;
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_g1 = 2'b01;
    sb.push_back('{port: 1'b0, data: 32'd7, err: 1'b0});
    sb.push_back('{port: 1'b0, data: 32'd7, err: 1'b0});
`else
    exp_g1 = 2'b10;
    sb.push_back('{port: 1'b0, data: 32'd7, err: 1'b0});
    sb.push_back('{port: 1'b1, data: 32'hFF, err: 1'b0});
`endif
    sb.push_back('{port: 1'b0, data: 32'd7, err: 1'b0});
    @(negedge clk);
    chk("t2_grant0", {30'b0, req_ready}, 32'h1);
    repeat (3) tick();
    @(negedge clk);
    chk("t2_grant1", {30'b0, req_ready}, {30'b0, exp_g1});
    repeat (3) tick();
    @(negedge clk);
    chk("t2_grant2", {30'b0, req_ready}, 32'h1);
    tick();
    req_valid = 2'b00;
    repeat (2) tick();
    chk("t2_sb_empty", sb.size(), 32'h0);

    // Backpressure on port 1, then a request landing in RESP.
    req1_SrcA = 32'hFFFF0000; req1_SrcB = 32'h0000FFFF; req1_Operation = 4'b0110;
    req_valid = 2'b10; rsp_ready = 2'b00;
    sb.push_back('{port: 1'b1, data: 32'hFFFFFFFF, err: 1'b0});
    @(negedge clk);
    chk("t3_ready_c0", {30'b0, req_ready}, 32'h2);
    tick();
    req_valid = 2'b00;
    tick();
    for (int i = 0; i < 5; i++) begin
      rsp_ready = (i >= 2) ? 2'b01 : 2'b00;
      @(negedge clk);
      chk("t3_hold_valid", {30'b0, rsp_valid}, 32'h2);
      chk("t3_hold_data", rsp_data, 32'hFFFFFFFF);
      tick();
    end
    rsp_ready = 2'b10;
    req0_SrcA = 32'd5; req0_SrcB = 32'd7; req0_Operation = 4'b0010;
    req_valid = 2'b01;
    sb.push_back('{port: 1'b0, data: 32'd12, err: 1'b0});
    @(negedge clk);
    chk("t3_no_accept_resp", {30'b0, req_ready}, 32'h0);
    tick();
    @(negedge clk);
    chk("t3_valid_cleared", {30'b0, rsp_valid}, 32'h0);
    chk("t3_next_grant", {30'b0, req_ready}, 32'h1);
    tick();
    req_valid = 2'b00; rsp_ready = 2'b11;
    repeat (2) tick();
    chk("t3_sb_empty", sb.size(), 32'h0);

    // Illegal op, then a legal compare.
    do_op(1'b0, 32'd3, 32'd4, 4'b1101, 32'h0, 1'b1);
    do_op(1'b0, 32'd9, 32'd9, 4'b1000, 32'h1, 1'b0);
    do_op(1'b1, 32'd1, 32'd2, 4'b1110, 32'h0, 1'b1);

    // Reset while in EXEC aborts the operation.
    req0_SrcA = 32'd1; req0_SrcB = 32'd2; req0_Operation = 4'b0010;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00; reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t5_rsp_valid", {30'b0, rsp_valid}, 32'h0);
    chk("t5_rsp_data", rsp_data, 32'h0);
    chk("t5_rsp_err", {31'b0, rsp_err}, 32'h0);
    chk("t5_alu_a", alu_SrcA, 32'h0);
    tick();
    @(negedge clk);
    chk("t5_still_idle", {30'b0, rsp_valid}, 32'h0);
    tick();
    req0_SrcA = 32'd10;   req0_SrcB = 32'd3;    req0_Operation = 4'b0011;
    req1_SrcA = 32'hF0;   req1_SrcB = 32'h0F;   req1_Operation = 4'b0110;
    req_valid = 2'b11; rsp_ready = 2'b11;
    sb.push_back('{port: 1'b0, data: 32'd7, err: 1'b0});
    sb.push_back('{port: 1'b1, data: 32'hFF, err: 1'b0});
    @(negedge clk);
    chk("t5_first_grant", {30'b0, req_ready}, 32'h1);
    tick();
    req_valid = 2'b10;
    repeat (2) tick();
    @(negedge clk);
    chk("t5_second_grant", {30'b0, req_ready}, 32'h2);
    tick();
    req_valid = 2'b00;
    repeat (2) tick();
    chk("t5_sb_empty", sb.size(), 32'h0);

    // Arithmetic shift passes straight through.
    do_op(1'b1, 32'h80000000, 32'd4, 4'b0111, 32'hF8000000, 1'b0);

    repeat (2) tick();
    chk("final_sb_empty", sb.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational `alu` instance between two requesters: port 0 is the execute stage and port 1 is the branch/address helper.
- Arbitrates round-robin and registers operands into the ALU.
- Captures the ALU result and returns it to the winning requester over a valid/ready handshake.
- Sits between the requesters and the ALU; drives the ALU's SrcA, SrcB and Operation inputs and reads its ALUResult.

Parameters:
- DATA_WIDTH, 32, operand/result width; must match the ALU.
- OPCODE_LENGTH, 4, ALU operation code width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  2  per-port request valid; bit i = port i.
- req_ready  out  2  per-port request accept.
- req0_SrcA, req0_SrcB  in  DATA_WIDTH  port 0 operands.
- req0_Operation  in  OPCODE_LENGTH  port 0 ALU op.
- req1_SrcA, req1_SrcB  in  DATA_WIDTH  port 1 operands.
- req1_Operation  in  OPCODE_LENGTH  port 1 ALU op.
- alu_SrcA, alu_SrcB  out  DATA_WIDTH  to ALU.
- alu_Operation  out  OPCODE_LENGTH  to ALU.
- alu_ALUResult  in  DATA_WIDTH  from ALU.
- rsp_valid  out  2  one-hot response valid; bit = owner port.
- rsp_ready  in  2  per-port response accept.
- rsp_data  out  DATA_WIDTH  captured ALU result.
- rsp_err  out  1  op code was illegal (1101 or 1110).

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high.
- State at reset:
  - state=IDLE, owner=0, last_grant=1, so port 0 has first priority.
  - Operand/op registers=0.
  - rsp_valid=00, rsp_data=0, rsp_err=0.
  - alu_* outputs=0; req_ready=00.
- FSM states: IDLE, EXEC, RESP.
- Grant (combinational):
  - Active in IDLE only.
  - Both ports valid: grant the port != last_grant.
  - One port valid: grant that port.
  - req_ready has the grant bit set only in IDLE; it is 00 in EXEC and RESP.
- Request handshake:
  - Requester holds valid, operands and op stable until accepted.
  - Dropping valid before acceptance is legal; nothing is recorded.
- IDLE→EXEC, on the edge where req_valid[g]&req_ready[g]:
  - Latch the port g operands and op.
  - owner<=g, last_grant<=g.
- EXEC:
  - alu_SrcA/alu_SrcB/alu_Operation are driven from the latched registers. Outside EXEC they are driven 0.
  - At the edge: rsp_data<=alu_ALUResult; rsp_err<=(op==1101 or op==1110); rsp_valid[owner]<=1; go to RESP.
- RESP:
  - Hold rsp_valid, rsp_data and rsp_err until rsp_ready[owner]=1.
  - On that edge: rsp_valid<=00, go to IDLE. rsp_data/rsp_err keep their value.
  - rsp_ready of the non-owner port is ignored.
- Latency and throughput:
  - Accept in cycle 0 → rsp_valid high in cycle 2.
  - With rsp_ready already high, IDLE in cycle 3 and the next accept in cycle 3.
  - Peak throughput is 1 op per 3 cycles.
- Arithmetic: none inside the block; the result is passed through unmodified at full DATA_WIDTH. Illegal ops pass through the ALU, which yields 0, so rsp_data=0 and rsp_err=1.
- Fairness: with both ports continuously valid, grants alternate 0,1,0,1,...
- Reset in EXEC or RESP:
  - Abort the operation; no response is delivered.
  - All registers return to reset values, including last_grant=1.
- Simultaneous events: a request arriving in RESP in the same cycle as response acceptance is not accepted that cycle. It is granted in the following IDLE cycle.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: strict priority, port 0 always wins when both ports are valid. last_grant is still updated but unused.
- Undefined (default): round-robin as above.
- Port list, latency and all other behaviour are identical in both builds.

Test Plan:
- Reset then single request: port 0 valid, SrcA=5, SrcB=7, op=0010 accepted in cycle 0. Expected: rsp_valid=01, rsp_data=12, rsp_err=0 in cycle 2; req_ready=00 during cycles 1-2.
- Contention: both ports valid every cycle, port 0 op=0011 (10,3), port 1 op=0110 (F0,0F). Expected: grants alternate 0,1,0; responses 7, FF, 7. With ALU_ARB_FIXED_PRIO_EN: port 0 only, responses 7, 7, 7.
- Backpressure: port 1 result 0xFFFFFFFF, rsp_ready=00 for 5 cycles. Expected: rsp_valid=10 and rsp_data held stable; rsp_ready=01 has no effect; rsp_ready=10 clears rsp_valid on the next edge.
- Illegal op: port 0 op=1101, SrcA=3, SrcB=4. Expected: rsp_data=0, rsp_err=1. A following op=1000 (9,9) returns rsp_data=1, rsp_err=0.
- Reset mid-operation: assert reset in EXEC. Expected: rsp_valid stays 00, all outputs 0 the next cycle; a subsequent simultaneous request from both ports grants port 0 first.
- Shift pass-through: op=0111, SrcA=0x80000000, SrcB=4. Expected: rsp_data=0xF8000000.
